// File: rtl/branch_compare_arbiter.sv
// Round-robin arbiter that shares one branch comparator between two requesters.
// The winning request is registered into a single result slot with valid/ready handoff.

package branch_compare_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } instruction_t;

endpackage

module comparator
  import branch_compare_arbiter_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  word_t      a_i,
  input  word_t      b_i,
  output logic       taken_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (a_i == b_i);
  assign lt_s = ($signed(a_i) < $signed(b_i));
  assign lt_u = (a_i < b_i);

  // Non-branch encodings (010/011) resolve as not taken.
  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      3'b000:  taken_o = eq;
      3'b001:  taken_o = !eq;
      3'b100:  taken_o = lt_s;
      3'b101:  taken_o = !lt_s;
      3'b110:  taken_o = lt_u;
      3'b111:  taken_o = !lt_u;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

module branch_compare_arbiter
  import branch_compare_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  instruction_t       req_instr_i [N_REQ],
  input  word_t              req_a_i     [N_REQ],
  input  word_t              req_b_i     [N_REQ],
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_id_o,
  output logic               rsp_taken_o,
  output logic               rsp_illegal_o
);

  logic         slot_valid_q, slot_valid_d;
  logic         slot_id_q,    slot_id_d;
  instruction_t slot_instr_q, slot_instr_d;
  word_t        slot_a_q,     slot_a_d;
  word_t        slot_b_q,     slot_b_d;
  logic         prio_q,       prio_d;

  logic         can_load;
  logic [1:0]   grant;
  logic         grant_any;
  logic         grant_id;

  assign can_load = !slot_valid_q || rsp_ready_i;

  // A requester only loses when the other is also valid and holds priority.
  always_comb begin
    grant = 2'b00;
    if (can_load) begin
      grant[0] = req_valid_i[0] && (!req_valid_i[1] || (prio_q == 1'b0));
      grant[1] = req_valid_i[1] && (!req_valid_i[0] || (prio_q == 1'b1));
    end
  end

  assign grant_any = |grant;
  assign grant_id  = grant[1];

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_id_d    = slot_id_q;
    slot_instr_d = slot_instr_q;
    slot_a_d     = slot_a_q;
    slot_b_d     = slot_b_q;
    prio_d       = prio_q;
    if (grant_any) begin
      slot_valid_d = 1'b1;
      slot_id_d    = grant_id;
      slot_instr_d = req_instr_i[grant_id];
      slot_a_d     = req_a_i[grant_id];
      slot_b_d     = req_b_i[grant_id];
      prio_d       = !grant_id;
    end else if (rsp_ready_i && slot_valid_q) begin
      slot_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      slot_valid_q <= 1'b0;
      slot_id_q    <= 1'b0;
      slot_instr_q <= '0;
      slot_a_q     <= '0;
      slot_b_q     <= '0;
      prio_q       <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_id_q    <= slot_id_d;
      slot_instr_q <= slot_instr_d;
      slot_a_q     <= slot_a_d;
      slot_b_q     <= slot_b_d;
      prio_q       <= prio_d;
    end
  end

  // Gate with reset so nothing is handed a ready while the slot is being cleared.
  assign req_ready_o = grant & {N_REQ{reset_ni}};

  comparator u_comparator (
    .funct3_i (slot_instr_q.funct3),
    .a_i      (slot_a_q),
    .b_i      (slot_b_q),
    .taken_o  (rsp_taken_o)
  );

  assign rsp_valid_o   = slot_valid_q;
  assign rsp_id_o      = slot_id_q;
  assign rsp_illegal_o = (slot_instr_q.funct3 == 3'b010) || (slot_instr_q.funct3 == 3'b011);

  logic unused_instr_bits;
  assign unused_instr_bits = ^{slot_instr_q.imm_hi, slot_instr_q.rs2, slot_instr_q.rs1,
                               slot_instr_q.imm_lo, slot_instr_q.opcode};

endmodule

// File: tb/tb_branch_compare_arbiter.sv
// Randomised scoreboard bench for branch_compare_arbiter.
// A predictor pushes expected results as grants happen; a monitor pops them as the consumer takes them.

module tb_branch_compare_arbiter;
   import branch_compare_arbiter_pkg::*;

   typedef struct packed {
      logic id;
      logic taken;
      logic illegal;
   } expect_t;

   logic         clk;
   logic         resetN;
   logic [1:0]   reqValid;
   logic [1:0]   reqReady;
   instruction_t reqInstr [2];
   word_t        reqA [2];
   word_t        reqB [2];
   logic         rspValid;
   logic         rspReady;
   logic         rspId;
   logic         rspTaken;
   logic         rspIllegal;

   int           checks;
   int           fails;
   expect_t      scoreboard [$];
   logic         modelFull;
   int           nextPrio;

   branch_compare_arbiter #(.N_REQ(2)) dut (
      .clk_i         (clk),
      .reset_ni      (resetN),
      .req_valid_i   (reqValid),
      .req_ready_o   (reqReady),
      .req_instr_i   (reqInstr),
      .req_a_i       (reqA),
      .req_b_i       (reqB),
      .rsp_valid_o   (rspValid),
      .rsp_ready_i   (rspReady),
      .rsp_id_o      (rspId),
      .rsp_taken_o   (rspTaken),
      .rsp_illegal_o (rspIllegal)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here so the counters stay honest.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Architectural branch rules written directly from the RISC-V definitions.
   function automatic logic refTaken(input logic [2:0] f3, input word_t a, input word_t b);
      int signed sa;
      int signed sb;
      sa = a;
      sb = b;
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return sa < sb;
         3'd5:    return sa >= sb;
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic instruction_t makeInstr(input logic [2:0] f3);
      instruction_t ins;
      ins = instruction_t'($urandom);
      ins.opcode = 7'b1100011;
      ins.funct3 = f3;
      return ins;
   endfunction

   // Decide which requester should win this cycle and queue the result it must produce.
   task automatic predictCycle();
      int   winner;
      logic [1:0] expReady;
      winner = -1;
      if (!modelFull || rspReady) begin
         if (reqValid[0] && reqValid[1]) winner = nextPrio;
         else if (reqValid[0])           winner = 0;
         else if (reqValid[1])           winner = 1;
      end
      expReady = (winner == 0) ? 2'b01 : (winner == 1) ? 2'b10 : 2'b00;
      checkOutput("req_ready", 32'(reqReady), 32'(expReady));
      if (winner >= 0) begin
         expect_t e;
         e.id      = winner[0];
         e.taken   = refTaken(reqInstr[winner].funct3, reqA[winner], reqB[winner]);
         e.illegal = (reqInstr[winner].funct3 == 3'b010) || (reqInstr[winner].funct3 == 3'b011);
         scoreboard.push_back(e);
         nextPrio  = 1 - winner;
         modelFull = 1'b1;
      end else if (rspReady) begin
         modelFull = 1'b0;
      end
   endtask

   // Drive one cycle of requests mid-cycle, then predict once the combinational ready has settled.
   task automatic applyStimulus(input logic v0, input logic [2:0] f0, input word_t a0, input word_t b0,
                                input logic v1, input logic [2:0] f1, input word_t a1, input word_t b1,
                                input logic rr);
      @(posedge clk);
      #2;
      reqValid    = {v1, v0};
      reqInstr[0] = makeInstr(f0);
      reqA[0]     = a0;
      reqB[0]     = b0;
      reqInstr[1] = makeInstr(f1);
      reqA[1]     = a1;
      reqB[1]     = b1;
      rspReady    = rr;
      #2;
      predictCycle();
   endtask

   function automatic word_t pickWord();
      case ($urandom_range(0, 3))
         0:       return 32'h8000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return word_t'($urandom_range(0, 15));
         default: return word_t'($urandom);
      endcase
   endfunction

   // Monitor: each cycle the slot must be full exactly when a result is owed, and must show the oldest one.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (resetN) begin
            checkOutput("rsp_valid", 32'(rspValid), 32'(scoreboard.size() != 0));
            if (rspValid && scoreboard.size() != 0) begin
               checkOutput("rsp_id", 32'(rspId), 32'(scoreboard[0].id));
               checkOutput("rsp_taken", 32'(rspTaken), 32'(scoreboard[0].taken));
               checkOutput("rsp_illegal", 32'(rspIllegal), 32'(scoreboard[0].illegal));
               if (rspReady) void'(scoreboard.pop_front());
            end
         end
      end
   end

   // Main sequence: reset, directed scenarios, random traffic, mid-run reset, drain.
   initial begin
      word_t ra;
      word_t rb;
      word_t pairA [3];
      word_t pairB [3];
      logic [2:0] branchF3 [6];
      checks      = 0;
      fails       = 0;
      modelFull   = 1'b0;
      nextPrio    = 0;
      resetN      = 1'b0;
      reqValid    = 2'b11;
      rspReady    = 1'b1;
      for (int i = 0; i < 2; i++) begin
         reqInstr[i] = makeInstr(3'b000);
         reqA[i]     = 32'd7;
         reqB[i]     = 32'd9;
      end

      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("reset req_ready", 32'(reqReady), 32'd0);
      checkOutput("reset rsp_id", 32'(rspId), 32'd0);
      checkOutput("reset rsp_taken", 32'(rspTaken), 32'd1);
      checkOutput("reset rsp_illegal", 32'(rspIllegal), 32'd0);
      reqValid = 2'b00;
      @(posedge clk);
      #2;
      resetN = 1'b1;

      $display("[TB] single request");
      applyStimulus(1, 3'b000, 32'd5, 32'd5, 0, 3'b000, 32'd0, 32'd0, 1);

      $display("[TB] tie and round-robin");
      repeat (4) applyStimulus(1, 3'b100, 32'hFFFF_FFFF, 32'd1, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 1);

      $display("[TB] backpressure");
      repeat (3) applyStimulus(1, 3'b000, 32'd1, 32'd2, 1, 3'b001, 32'd1, 32'd2, 0);
      applyStimulus(1, 3'b000, 32'd1, 32'd2, 1, 3'b001, 32'd1, 32'd2, 1);

      $display("[TB] illegal funct3");
      applyStimulus(0, 3'b000, 32'd0, 32'd0, 1, 3'b010, 32'd0, 32'd0, 1);
      applyStimulus(0, 3'b000, 32'd0, 32'd0, 1, 3'b011, 32'd4, 32'd4, 1);

      $display("[TB] full sweep");
      pairA    = '{32'h8000_0000, 32'd3, 32'd2};
      pairB    = '{32'h7FFF_FFFF, 32'd3, 32'd9};
      branchF3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
      for (int f = 0; f < 6; f++)
         for (int p = 0; p < 3; p++)
            applyStimulus(1, branchF3[f], pairA[p], pairB[p], 0, 3'b000, 32'd0, 32'd0, 1);

      $display("[TB] random traffic");
      for (int n = 0; n < 300; n++) begin
         word_t a0, b0, a1, b1;
         a0 = pickWord();
         b0 = ($urandom_range(0, 3) == 0) ? a0 : pickWord();
         a1 = pickWord();
         b1 = ($urandom_range(0, 3) == 0) ? a1 : pickWord();
         applyStimulus(1'($urandom_range(0, 1)), 3'($urandom), a0, b0,
                       1'($urandom_range(0, 1)), 3'($urandom), a1, b1,
                       ($urandom_range(0, 3) != 0));
      end

      $display("[TB] reset mid-operation");
      applyStimulus(1, 3'b000, 32'd1, 32'd1, 0, 3'b000, 32'd0, 32'd0, 1);
      @(posedge clk);
      #2;
      checkOutput("pre-reset rsp_valid", 32'(rspValid), 32'd1);
      reqValid = 2'b00;
      rspReady = 1'b0;
      resetN   = 1'b0;
      #1;
      checkOutput("async reset rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("async reset req_ready", 32'(reqReady), 32'd0);
      scoreboard.delete();
      modelFull = 1'b0;
      nextPrio  = 0;
      @(posedge clk);
      #2;
      resetN = 1'b1;
      applyStimulus(1, 3'b001, 32'd3, 32'd4, 1, 3'b001, 32'd3, 32'd3, 1);
      applyStimulus(1, 3'b000, 32'd3, 32'd4, 1, 3'b000, 32'd3, 32'd3, 1);

      repeat (3) applyStimulus(0, 3'b000, 32'd0, 32'd0, 0, 3'b000, 32'd0, 32'd0, 1);
      @(posedge clk);
      #4;
      checkOutput("scoreboard drained", 32'(scoreboard.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
